// File: rtl/dot_matrix_scan_ctrl_if.sv
// Host and divider-facing signals of the dot-matrix row-scan controller.
// The master drives strobes and writes; the slave is the scan controller.
interface dot_matrix_scan_ctrl_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic            tick;
    logic            en;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [COLS-1:0] wr_data;
    logic            swap_req;
    logic            swap_ack;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_data;
    logic            frame_start;

    modport master (
        output tick, en, wr_en, wr_addr, wr_data, swap_req,
        input  swap_ack, row_sel, col_data, frame_start
    );

    modport slave (
        input  tick, en, wr_en, wr_addr, wr_data, swap_req,
        output swap_ack, row_sel, col_data, frame_start
    );
endinterface

// File: rtl/dot_matrix_scan_ctrl.sv
// Row-scan sequencer for an 8x8 dot-matrix display with a double-buffered frame
// store and clk-timed blanking between rows.
module dot_matrix_scan_ctrl #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int BLANK_CYCLES = 2
) (
    input logic                   clk,
    input logic                   rst,
    dot_matrix_scan_ctrl_if.slave bus
);
    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [AW-1:0] LAST_ROW   = AW'(ROWS - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   row_idx, row_idx_nx;
    logic [CW-1:0]   blank_cnt, blank_cnt_nx;
    logic            front;
    logic            pending;
    logic [COLS-1:0] frame_mem [2][ROWS];

    logic            wrap_tick;
    logic            swap_fire;
    logic [ROWS-1:0] row_sel_nx;
    logic [COLS-1:0] col_data_nx;
    logic            frame_start_nx;

    logic [ROWS-1:0] row_sel_p0;
    logic [COLS-1:0] col_data_p0;
    logic            swap_ack_p0;
    logic            frame_start_p0;

    assign wrap_tick = (state == S_SHOW) && bus.en && bus.tick && (row_idx == LAST_ROW);
    assign swap_fire = wrap_tick && (pending || bus.swap_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            row_idx   <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_nx;
            row_idx   <= row_idx_nx;
            blank_cnt <= blank_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        row_idx_nx   = row_idx;
        blank_cnt_nx = blank_cnt;
        if (!bus.en) begin
            state_nx     = S_IDLE;
            row_idx_nx   = '0;
            blank_cnt_nx = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx     = S_BLANK;
                    row_idx_nx   = '0;
                    blank_cnt_nx = BLANK_LOAD;
                end
                S_BLANK: begin
                    if (blank_cnt == '0) state_nx = S_SHOW;
                    else                 blank_cnt_nx = blank_cnt - CW'(1);
                end
                S_SHOW: begin
                    // Ticks only count while a row is lit; IDLE/BLANK ticks are dropped.
                    if (bus.tick) begin
                        state_nx     = S_BLANK;
                        blank_cnt_nx = BLANK_LOAD;
                        row_idx_nx   = (row_idx == LAST_ROW) ? '0 : row_idx + AW'(1);
                    end
                end
                default: begin
                    state_nx   = S_IDLE;
                    row_idx_nx = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so the registered drive lines up with it.
    always_comb begin
        row_sel_nx     = '0;
        col_data_nx    = '0;
        frame_start_nx = 1'b0;
        if (state_nx == S_SHOW) begin
            row_sel_nx     = ROWS'(1) << row_idx_nx;
            col_data_nx    = frame_mem[front][row_idx_nx];
            frame_start_nx = (state != S_SHOW) && (row_idx_nx == '0);
        end
    end

    // Writes address the pre-swap back buffer, which a coincident swap turns into the front.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    frame_mem[b][r] <= '0;
        end else if (bus.wr_en && (int'(bus.wr_addr) < ROWS)) begin
            frame_mem[~front][bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front   <= 1'b0;
            pending <= 1'b0;
        end else if (swap_fire) begin
            front   <= ~front;
            pending <= 1'b0;
        end else if (bus.swap_req) begin
            pending <= 1'b1;
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_sel_p0     <= '0;
            col_data_p0    <= '0;
            swap_ack_p0    <= 1'b0;
            frame_start_p0 <= 1'b0;
        end else begin
            row_sel_p0     <= row_sel_nx;
            col_data_p0    <= col_data_nx;
            swap_ack_p0    <= swap_fire;
            frame_start_p0 <= frame_start_nx;
        end
    end

    assign bus.row_sel     = row_sel_p0;
    assign bus.col_data    = col_data_p0;
    assign bus.swap_ack    = swap_ack_p0;
    assign bus.frame_start = frame_start_p0;
endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Bench for dot_matrix_scan_ctrl: directed scenarios plus randomized traffic,
// all checked against a behavioural display model.
module tb_dot_matrix_scan_ctrl;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int BLANK = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dot_matrix_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    dot_matrix_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .BLANK_CYCLES(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: frame store, which buffer is shown, and the visible row.
    logic [7:0] m_buf [2][ROWS];
    int m_front, m_pending, m_running, m_row, m_blank;
    logic [7:0] e_row_sel, e_col;
    logic e_ack, e_fs;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++) m_buf[b][r] = 8'h00;
        m_front = 0; m_pending = 0; m_running = 0; m_row = 0; m_blank = 0;
        e_row_sel = 8'h00; e_col = 8'h00; e_ack = 1'b0; e_fs = 1'b0;
    endfunction

    function automatic void model_edge();
        bit showing, wrap, swap;
        showing = (m_running != 0) && (m_blank == 0);
        wrap    = bus.en && showing && bus.tick && (m_row == ROWS - 1);
        swap    = wrap && ((m_pending != 0) || bus.swap_req);
        if (bus.wr_en && bus.wr_addr < ROWS) m_buf[1 - m_front][bus.wr_addr] = bus.wr_data;
        if (swap) begin
            m_front = 1 - m_front;
            m_pending = 0;
        end else if (bus.swap_req) m_pending = 1;
        e_ack = swap;
        e_fs = 1'b0;
        if (!bus.en) begin
            m_running = 0; m_row = 0; m_blank = 0;
        end else if (m_running == 0) begin
            m_running = 1; m_row = 0; m_blank = BLANK;
        end else if (m_blank > 0) begin
            m_blank--;
            if (m_blank == 0 && m_row == 0) e_fs = 1'b1;
        end else if (bus.tick) begin
            m_row = (m_row + 1) % ROWS;
            m_blank = BLANK;
        end
        if (m_running != 0 && m_blank == 0) begin
            e_row_sel = 8'(1 << m_row);
            e_col = m_buf[m_front][m_row];
        end else begin
            e_row_sel = 8'h00;
            e_col = 8'h00;
        end
    endfunction

    function automatic string got_str();
        return $sformatf("got rs=%h cd=%h ack=%b fs=%b want rs=%h cd=%h ack=%b fs=%b",
                         bus.row_sel, bus.col_data, bus.swap_ack, bus.frame_start,
                         e_row_sel, e_col, e_ack, e_fs);
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet_inputs();
        bus.tick = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.swap_req = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        bus.en = 1'b0;
        rst = 1'b0;
        model_reset();
        #12;
        vectors++;
        if (bus.row_sel !== 8'h00 || bus.col_data !== 8'h00 || bus.swap_ack !== 1'b0 || bus.frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs %s", got_str());
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            vectors++;
            if (bus.row_sel !== e_row_sel || bus.col_data !== e_col || bus.swap_ack !== e_ack || bus.frame_start !== e_fs) begin
                miscompares++;
                $display("FAIL reset_idle c=%0d %s", c, got_str());
            end
        end
    endtask

    task automatic test_scan();
        int zeros = 0;
        int k = 0;
        logic [7:0] prev = 8'h00;
        bus.en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            bus.tick = (c % 20 == 19);
            cyc();
            vectors++;
            if (bus.row_sel !== e_row_sel || bus.col_data !== e_col || bus.swap_ack !== e_ack || bus.frame_start !== e_fs) begin
                miscompares++;
                $display("FAIL scan c=%0d %s", c, got_str());
            end
            if (bus.row_sel == 8'h00) zeros++;
            else if (prev == 8'h00) begin
                vectors++;
                if (bus.row_sel !== 8'(1 << (k % 8)) || zeros != BLANK) begin
                    miscompares++;
                    $display("FAIL scan_order k=%0d got rs=%h blank=%0d want rs=%h blank=%0d",
                             k, bus.row_sel, zeros, 8'(1 << (k % 8)), BLANK);
                end
                k++;
                zeros = 0;
            end
            prev = bus.row_sel;
        end
        quiet_inputs();
    endtask

    task automatic test_swap();
        bit acked = 0;
        bit done = 0;
        for (int c = 0; c < 1000 && !done; c++) begin
            bus.wr_en = (c < 8);
            bus.wr_addr = 3'(c);
            bus.wr_data = 8'(8'hA0 + c);
            bus.swap_req = (c == 8);
            bus.tick = (bus.row_sel != 8'h00) && ($urandom_range(0, 3) == 0);
            cyc();
            vectors++;
            if (bus.row_sel !== e_row_sel || bus.col_data !== e_col || bus.swap_ack !== e_ack || bus.frame_start !== e_fs) begin
                miscompares++;
                $display("FAIL swap c=%0d %s", c, got_str());
            end
            if (bus.swap_ack) acked = 1;
            if (acked && bus.row_sel == 8'h08) begin
                vectors++;
                if (bus.col_data !== 8'hA3) begin
                    miscompares++;
                    $display("FAIL swap_row3 got cd=%h want cd=a3", bus.col_data);
                end
                done = 1;
            end
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL swap_timeout got ack=%b want ack=1 then row 3", acked);
        end
        quiet_inputs();
    endtask

    task automatic test_swap_same_edge();
        bit found = 0;
        int acks = 0;
        int fs = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
            bus.tick = (bus.row_sel != 8'h00) && ($urandom_range(0, 2) == 0);
            cyc();
            if (bus.row_sel == 8'h80) found = 1;
        end
        bus.tick = 1'b1;
        bus.swap_req = 1'b1;
        cyc();
        quiet_inputs();
        vectors++;
        if (!found || bus.swap_ack !== 1'b1 || e_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL swap_same_edge got ack=%b row7_found=%b want ack=1", bus.swap_ack, found);
        end
        for (int c = 0; c < 2000 && fs < 3; c++) begin
            bus.swap_req = (c == 3 || c == 10);
            bus.tick = (bus.row_sel != 8'h00) && ($urandom_range(0, 2) == 0);
            cyc();
            vectors++;
            if (bus.row_sel !== e_row_sel || bus.col_data !== e_col || bus.swap_ack !== e_ack || bus.frame_start !== e_fs) begin
                miscompares++;
                $display("FAIL swap_pending c=%0d %s", c, got_str());
            end
            if (bus.swap_ack) acks++;
            if (bus.frame_start) fs++;
        end
        vectors++;
        if (acks != 1 || fs != 3) begin
            miscompares++;
            $display("FAIL double_swap_req got acks=%0d frames=%0d want acks=1 frames=3", acks, fs);
        end
        quiet_inputs();
    endtask

    task automatic test_enable();
        bit found = 0;
        bit acked = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
            bus.tick = (bus.row_sel != 8'h00) && ($urandom_range(0, 2) == 0);
            cyc();
            if (bus.row_sel == 8'h20) found = 1;
        end
        bus.tick = 1'b0;
        bus.en = 1'b0;
        bus.swap_req = 1'b1;
        cyc();
        bus.swap_req = 1'b0;
        vectors++;
        if (!found || bus.row_sel !== 8'h00 || bus.col_data !== 8'h00) begin
            miscompares++;
            $display("FAIL en_off got rs=%h cd=%h row5_found=%b want rs=00 cd=00", bus.row_sel, bus.col_data, found);
        end
        bus.en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            vectors++;
            if (bus.row_sel !== ((c == 2) ? 8'h01 : 8'h00) || bus.frame_start !== (c == 2)) begin
                miscompares++;
                $display("FAIL en_restart c=%0d got rs=%h fs=%b want rs=%h fs=%b",
                         c, bus.row_sel, bus.frame_start, (c == 2) ? 8'h01 : 8'h00, (c == 2));
            end
        end
        for (int c = 0; c < 1000 && !acked; c++) begin
            bus.tick = (bus.row_sel != 8'h00) && ($urandom_range(0, 2) == 0);
            cyc();
            vectors++;
            if (bus.row_sel !== e_row_sel || bus.col_data !== e_col || bus.swap_ack !== e_ack || bus.frame_start !== e_fs) begin
                miscompares++;
                $display("FAIL en_pending c=%0d %s", c, got_str());
            end
            if (bus.swap_ack) acked = 1;
        end
        vectors++;
        if (!acked) begin
            miscompares++;
            $display("FAIL en_pending_swap got ack=0 want ack=1");
        end
        quiet_inputs();
    endtask

    task automatic test_blank_tick_reset();
        logic [7:0] r;
        bit acked = 0;
        bit done = 0;
        for (int c = 0; c < 10 && bus.row_sel == 8'h00; c++) cyc();
        r = bus.row_sel;
        bus.tick = 1'b1;
        cyc();
        cyc();
        bus.tick = 1'b0;
        cyc();
        vectors++;
        if (bus.row_sel !== {r[6:0], r[7]} || bus.row_sel !== e_row_sel) begin
            miscompares++;
            $display("FAIL blank_tick got rs=%h want rs=%h", bus.row_sel, {r[6:0], r[7]});
        end
        for (int c = 0; c < 5; c++) begin
            cyc();
            vectors++;
            if (bus.row_sel !== {r[6:0], r[7]}) begin
                miscompares++;
                $display("FAIL row_hold c=%0d got rs=%h want rs=%h", c, bus.row_sel, {r[6:0], r[7]});
            end
        end
        bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 8'h5A; bus.swap_req = 1'b1;
        cyc();
        quiet_inputs();
        for (int c = 0; c < 2000 && !done; c++) begin
            bus.tick = (bus.row_sel != 8'h00) && ($urandom_range(0, 2) == 0);
            cyc();
            if (bus.swap_ack) acked = 1;
            if (acked && bus.row_sel == 8'h80) done = 1;
        end
        vectors++;
        if (!done || bus.col_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL addr7_write got cd=%h reached=%b want cd=5a", bus.col_data, done);
        end
        bus.tick = 1'b0;
        #3 rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (bus.row_sel !== 8'h00 || bus.col_data !== 8'h00 || bus.swap_ack !== 1'b0 || bus.frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset %s", got_str());
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            vectors++;
            if (bus.row_sel !== e_row_sel || bus.col_data !== e_col || bus.swap_ack !== e_ack || bus.frame_start !== e_fs) begin
                miscompares++;
                $display("FAIL after_reset c=%0d %s", c, got_str());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            bus.en = ($urandom_range(0, 49) != 0);
            bus.tick = ($urandom_range(0, 3) == 0);
            bus.wr_en = $urandom_range(0, 1);
            bus.wr_addr = 3'($urandom_range(0, 7));
            bus.wr_data = 8'($urandom);
            bus.swap_req = ($urandom_range(0, 39) == 0);
            cyc();
            vectors++;
            if (bus.row_sel !== e_row_sel || bus.col_data !== e_col || bus.swap_ack !== e_ack || bus.frame_start !== e_fs) begin
                miscompares++;
                $display("FAIL random c=%0d %s", c, got_str());
            end
        end
        quiet_inputs();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_swap();
        test_swap_same_edge();
        test_enable();
        test_blank_tick_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
